btb_file: RTL

BTB_FILE -- requirements
Module: btb_file

---
 rtl/btb_pkg.sv | 42 ++++
 rtl/btb_flush_ctrl.sv | 53 +++++
 rtl/btb_file.sv | 101 ++++++++++
 3 files changed

// File: rtl/btb_pkg.sv
// btb_pkg: shared constants and types for the branch target buffer storage.
//   - Geometry: BTB_SETS sets of SET_W bits, two WAY_W-bit ways per set.
//   - Way layout: valid | tag | target | state | pad (bit positions below).
//   - flush_state_e: states of the flush sweep controller.
//   - clear_valid(): returns a set with both way valid bits cleared.
package btb_pkg;

  localparam int BTB_SETS = 8;
  localparam int IDX_W    = 3;
  localparam int SET_W    = 128;
  localparam int WAY_W    = 64;

  // Field positions within one way.
  localparam int VALID_BIT = 63;
  localparam int TAG_HI    = 62;
  localparam int TAG_LO    = 36;
  localparam int TARGET_HI = 35;
  localparam int TARGET_LO = 4;
  localparam int STATE_HI  = 3;
  localparam int STATE_LO  = 2;

  // Valid bits of way1 (upper half) and way2 (lower half) within a set.
  localparam int WAY1_VALID = WAY_W + VALID_BIT;
  localparam int WAY2_VALID = VALID_BIT;

  localparam logic [1:0] STRONG_NOT_TAKEN = 2'b00;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Invalidate both ways while keeping tag/target/state for debug visibility.
  function automatic logic [SET_W-1:0] clear_valid(input logic [SET_W-1:0] set_in);
    logic [SET_W-1:0] set_out;
    set_out             = set_in;
    set_out[WAY1_VALID] = 1'b0;
    set_out[WAY2_VALID] = 1'b0;
    return set_out;
  endfunction

endpackage

// File: rtl/btb_flush_ctrl.sv
// btb_flush_ctrl: sweeps all BTB sets once per flush request, one set per cycle.
// Ports:
//   clk, rst_n    - clock and synchronous active-low reset
//   flush         - one-cycle request; ignored while a sweep is running
//   busy          - high while the sweep is in progress (exactly BTB_SETS cycles)
//   clr_en        - clear strobe for set clr_index this cycle
//   clr_index     - set being cleared
module btb_flush_ctrl
  import btb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  output logic             busy,
  output logic             clr_en,
  output logic [IDX_W-1:0] clr_index
);

  flush_state_e     state_reg;
  logic [IDX_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg <= FLUSH;
          end
          count_reg <= '0;
        end
        FLUSH: begin
          // Counter wraps 7 -> 0 naturally on the final clear.
          if (count_reg == IDX_W'(BTB_SETS - 1)) begin
            state_reg <= IDLE;
          end
          count_reg <= count_reg + 1'b1;
        end
        default: begin
          state_reg <= IDLE;
          count_reg <= '0;
        end
      endcase
    end
  end

  assign busy      = (state_reg == FLUSH);
  assign clr_en    = busy;
  assign clr_index = count_reg;

endmodule

// File: rtl/btb_file.sv
// btb_file: 8-set, 2-way branch target buffer storage with per-set LRU bit.
// Ports:
//   clk, rst_n       - clock and synchronous active-low reset
//   read_index       - IF-stage lookup index; read_set/read_LRU are its contents
//   read_set         - set contents (way1 [127:64], way2 [63:0]); write-first
//                      bypass from write_set, forced to zero while busy
//   read_LRU         - LRU bit of read_index, same bypass/force rules
//   update_index     - EX-stage read-modify-write index
//   update_set       - stored contents of update_index (never bypassed)
//   LRU              - full LRU vector, one bit per set
//   write_en         - commit write_set/next_LRU_write to update_index
//   write_set        - new set contents
//   next_LRU_write   - new LRU bit
//   flush            - one-cycle pulse: invalidate all entries over 8 cycles
//   busy             - flush sweep in progress; writes are dropped meanwhile
module btb_file
  import btb_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_W-1:0]    read_index,
  output logic [SET_W-1:0]    read_set,
  output logic                read_LRU,
  input  logic [IDX_W-1:0]    update_index,
  output logic [SET_W-1:0]    update_set,
  output logic [BTB_SETS-1:0] LRU,
  input  logic                write_en,
  input  logic [SET_W-1:0]    write_set,
  input  logic                next_LRU_write,
  input  logic                flush,
  output logic                busy
);

  logic             clr_en;
  logic [IDX_W-1:0] clr_index;
  logic             wr_ok;
  logic             bypass;

  logic [SET_W-1:0]    set_mem [BTB_SETS];
  logic [BTB_SETS-1:0] lru_vec;

  btb_flush_ctrl u_flush_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .busy      (busy),
    .clr_en    (clr_en),
    .clr_index (clr_index)
  );

  // Writes are only honoured outside a sweep; a write coinciding with the
  // flush request lands first and is then invalidated by the sweep.
  assign wr_ok = write_en && !busy;

  genvar gi;
  generate
    for (gi = 0; gi < BTB_SETS; gi++) begin : g_set
      logic [SET_W-1:0] set_reg;
      logic             lru_reg;
      logic             wr_hit;
      logic             clr_hit;

      assign wr_hit  = wr_ok  && (update_index == IDX_W'(gi));
      assign clr_hit = clr_en && (clr_index    == IDX_W'(gi));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          set_reg <= '0;
          lru_reg <= 1'b0;
        end else if (wr_hit) begin
          set_reg <= write_set;
          lru_reg <= next_LRU_write;
        end else if (clr_hit) begin
          set_reg <= clear_valid(set_reg);
          lru_reg <= 1'b0;
        end
      end

      assign set_mem[gi] = set_reg;
      assign lru_vec[gi] = lru_reg;
    end
  endgenerate

  assign bypass = wr_ok && (update_index == read_index);

  always_comb begin
    read_set = set_mem[read_index];
    read_LRU = lru_vec[read_index];
    if (busy) begin
      read_set = '0;
      read_LRU = 1'b0;
    end else if (bypass) begin
      read_set = write_set;
      read_LRU = next_LRU_write;
    end
  end

  assign update_set = set_mem[update_index];
  assign LRU        = lru_vec;

endmodule
